storage_loader: RTL
===================

STORAGE_LOADER -- requirements
Module: storage_loader

Interface
REQ-001 SHALL have parameter ELEM_W, default 16, meaning bits per matrix element.
REQ-002 SHALL have parameter ELEMS, default 3, meaning elements packed per storage row.
REQ-003 SHALL have parameter CHANNELS, default 3, meaning target storages (0=code, 1=weight, 2=input).
REQ-004 SHALL have parameter IDX_W, default 32, meaning layer/row index width.
REQ-005 SHALL use one clock and an asynchronous active-low reset.
REQ-006 SHALL have port clk_clk, input, 1 bit: the single clock.
REQ-007 SHALL have port reset_reset_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1): command handshake.
REQ-009 SHALL have ports cmd_channel (input, 8), cmd_layer (input, IDX_W) and cmd_rows (input, IDX_W): target storage, layer index and row count.
REQ-010 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, ELEM_W): element stream.
REQ-011 SHALL have port abort, input, 1 bit: cancel the active command.
REQ-012 SHALL have port wr_en, output, CHANNELS bits: one-hot is_write per storage.
REQ-013 SHALL have ports wr_data (output, ELEMS*ELEM_W), wr_layer (output, IDX_W) and wr_row (output, IDX_W).
REQ-014 SHALL have ports busy, done and err (outputs, 1 bit each).
REQ-015 SHALL have port loaded, output, CHANNELS bits: sticky flag per storage.
REQ-016 SHALL have port ctrl_enable_ok, output, 1 bit: AND of loaded[0] and loaded[1].

Function
REQ-017 SHALL implement FSM states IDLE, PACK, WRITE, DONE; cmd_ready=1 only in IDLE.
REQ-018 SHALL, on a cmd handshake, latch channel/layer/rows, clear row counter and element counter, and go to PACK.
REQ-019 SHALL, if cmd_channel>=CHANNELS or cmd_rows==0, go directly to DONE with err=1 and no wr_en.
REQ-020 SHALL, in PACK, hold in_ready=1 and accept one element per in_valid cycle; gaps stall without loss.
REQ-021 SHALL place the first element of a row in the MSBs of wr_data, MSB-first order.
REQ-022 SHALL go to WRITE in the cycle after the ELEMS-th element is accepted, with in_ready=0 in WRITE.
REQ-023 SHALL, in WRITE, assert for exactly one cycle wr_en[channel]=1 with wr_layer=latched layer and wr_row=row counter.
REQ-024 SHALL, after WRITE, increment the row counter and return to PACK; when row counter+1==rows, go to DONE instead.
REQ-025 SHALL, in DONE, pulse done for one cycle, set loaded[channel] (on success only) and return to IDLE.
REQ-026 SHALL, on abort in PACK or WRITE, suppress that cycle's wr_en, go to DONE with err=1, and leave loaded unchanged.
REQ-027 SHALL hold busy=1 in every state other than IDLE.
REQ-028 SHALL hold wr_data, wr_layer and wr_row stable and wr_en=0 outside WRITE.
REQ-029 SHALL keep the row counter IDX_W bits wide; cmd_rows up to 2^IDX_W-1 SHALL be legal with no wrap before completion.

Reset
REQ-030 SHALL, with reset_reset_n=0, immediately force state IDLE and set wr_en, done, err, busy, loaded and all counters to 0, and wr_data/wr_layer/wr_row to 0.
REQ-031 SHALL, on reset mid-command, discard the partial row; no write SHALL occur after reset release until a new command.

Structure
REQ-032 SHALL place the channel index constants (CH_CODE=0, CH_WEIGHT=1, CH_INPUT=2) and the FSM state enum in a shared package, storage_loader_pkg.
REQ-033 SHALL implement element packing (shift register plus element counter) in one sub-module, row_packer.

Verification
REQ-034 SHALL cover: cmd ch=1, layer=2, rows=2, elements 0x0001..0x0006 back-to-back -> wr_en=3'b010 twice; wr_data=0x000100020003 with row 0, then 0x000400050006 with row 1; layer=2 both; done once; loaded=3'b010.
REQ-035 SHALL cover: same command with in_valid low every other cycle -> identical writes, only later.
REQ-036 SHALL cover: cmd ch=3 or rows=0 -> no wr_en, err=1 and done=1 in the same cycle, loaded unchanged.
REQ-037 SHALL cover: abort after 2 elements of row 0 -> no wr_en, err=1 and done=1, next command accepted normally.
REQ-038 SHALL cover: reset_reset_n low mid-PACK -> all outputs 0 asynchronously, cmd_ready=1 after release, no stale write.
REQ-039 SHALL cover: load ch0 then ch1 -> ctrl_enable_ok rises the cycle after the second done.

Source files
------------

// File: rtl/storage_loader_pkg.sv
// Shared channel indices and FSM state encoding for the storage loader.
package storage_loader_pkg;

    localparam int CH_CODE   = 0;
    localparam int CH_WEIGHT = 1;
    localparam int CH_INPUT  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/row_packer.sv
// Packs ELEMS elements into one storage row, first element in the MSBs.
// row_next is the row as it will look once the current element is taken,
// so the caller can capture a complete row in the same cycle as the last
// element arrives.
module row_packer #(
    parameter int ELEM_W = 16,
    parameter int ELEMS  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    accept,
    input  logic [ELEM_W-1:0]       in_data,
    output logic [ELEMS*ELEM_W-1:0] row_next,
    output logic                    last
);
    localparam int CW = $clog2(ELEMS + 1);

    // Only the ELEMS-1 elements already seen need storage; the final one is
    // taken straight from in_data.
    logic [(ELEMS-1)*ELEM_W-1:0] shreg;
    logic [CW-1:0]               cnt;

    assign row_next = {shreg, in_data};
    assign last     = accept && (cnt == CW'(ELEMS - 1));

    // Shift accepted elements in from the LSB end; counter wraps per row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (clear) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= row_next[(ELEMS-1)*ELEM_W-1:0];
            cnt   <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/storage_loader.sv
// Streams matrix elements into one of several row storages: packs ELEMS
// elements per row, emits one write per row, flags completion per storage.
module storage_loader
    import storage_loader_pkg::*;
#(
    parameter int ELEM_W   = 16,
    parameter int ELEMS    = 3,
    parameter int CHANNELS = 3,
    parameter int IDX_W    = 32
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [7:0]              cmd_channel,
    input  logic [IDX_W-1:0]        cmd_layer,
    input  logic [IDX_W-1:0]        cmd_rows,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ELEM_W-1:0]       in_data,
    input  logic                    abort,
    output logic [CHANNELS-1:0]     wr_en,
    output logic [ELEMS*ELEM_W-1:0] wr_data,
    output logic [IDX_W-1:0]        wr_layer,
    output logic [IDX_W-1:0]        wr_row,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [CHANNELS-1:0]     loaded,
    output logic                    ctrl_enable_ok
);
    localparam logic [7:0] CH_LIM = 8'(CHANNELS);

    state_t                   state_q, state_d;
    logic [7:0]               ch_q;
    logic [IDX_W-1:0]         layer_q, rows_q, row_cnt;
    logic                     err_q;
    logic                     cmd_fire, cmd_bad, accept, pk_last, last_row;
    logic [ELEMS*ELEM_W-1:0]  row_next;

    assign cmd_fire = (state_q == IDLE) && cmd_valid;
    assign cmd_bad  = (cmd_channel >= CH_LIM) || (cmd_rows == '0);
    assign accept   = in_ready && in_valid;
    // rows_q is non-zero whenever this matters, so the subtract cannot wrap.
    assign last_row = (row_cnt == rows_q - 1'b1);

    assign ctrl_enable_ok = loaded[CH_CODE] & loaded[CH_WEIGHT];

    row_packer #(.ELEM_W(ELEM_W), .ELEMS(ELEMS)) u_packer (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .clear    (cmd_fire),
        .accept   (accept),
        .in_data  (in_data),
        .row_next (row_next),
        .last     (pk_last)
    );

    // State register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state_q <= IDLE;
        else                state_q <= state_d;
    end

    // Next-state and handshake/strobe decode.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        wr_en     = '0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_d = cmd_bad ? DONE : PACK;
            end
            PACK: begin
                in_ready = 1'b1;
                if (abort)        state_d = DONE;
                else if (pk_last) state_d = WRITE;
            end
            WRITE: begin
                if (abort) begin
                    state_d = DONE;
                end else begin
                    for (int i = 0; i < CHANNELS; i++) wr_en[i] = (ch_q == 8'(i));
                    state_d = last_row ? DONE : PACK;
                end
            end
            DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Command latch, row counter, write-port registers and sticky flags.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ch_q     <= '0;
            layer_q  <= '0;
            rows_q   <= '0;
            row_cnt  <= '0;
            err_q    <= 1'b0;
            wr_data  <= '0;
            wr_layer <= '0;
            wr_row   <= '0;
            loaded   <= '0;
        end else begin
            if (cmd_fire) begin
                ch_q    <= cmd_channel;
                layer_q <= cmd_layer;
                rows_q  <= cmd_rows;
                row_cnt <= '0;
                err_q   <= cmd_bad;
            end
            // Capture the full row on the way into WRITE so the write port
            // only ever changes at that boundary.
            if (state_q == PACK && pk_last && !abort) begin
                wr_data  <= row_next;
                wr_layer <= layer_q;
                wr_row   <= row_cnt;
            end
            if (state_q == WRITE && !abort) row_cnt <= row_cnt + 1'b1;
            if ((state_q == PACK || state_q == WRITE) && abort) err_q <= 1'b1;
            if (state_q == DONE && !err_q) begin
                for (int i = 0; i < CHANNELS; i++)
                    if (ch_q == 8'(i)) loaded[i] <= 1'b1;
            end
        end
    end

endmodule
